// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (adds a misalign flag per FIFO entry).
package fetch_pkg;

  localparam int          FIFO_DEPTH = 2;
  localparam logic [1:0]  FIFO_FULL  = 2'(FIFO_DEPTH);
  localparam logic [31:0] NOP_INSTR  = 32'h00000013;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DROP
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        misalign;
`endif
  } fifo_entry_t;

  localparam int ENTRY_W = $bits(fifo_entry_t);

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry instruction buffer between the fetch FSM and decode.
// A clear empties it in one cycle and takes priority over push and pop.
module fetch_fifo
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_data,
  input  logic               pop,
  output logic [ENTRY_W-1:0] head,
  output logic               not_empty,
  output logic [1:0]         count
);

  logic [ENTRY_W-1:0] entries [FIFO_DEPTH];
  logic               rd_ptr;
  logic               wr_ptr;
  logic [1:0]         count_q;

  // Storage, pointers and occupancy; push and pop in one cycle leave the count alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entries[0] <= '0;
      entries[1] <= '0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      count_q    <= 2'd0;
    end else if (clear) begin
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (push) begin
        entries[wr_ptr] <= push_data;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign not_empty = (count_q != 2'd0);
  assign count     = count_q;
  // Head reads as zero when empty so decode never sees stale data
  assign head      = not_empty ? entries[rd_ptr] : '0;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one outstanding memory request, two-entry buffer to decode,
// redirect (Flush) handling that discards in-flight responses.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (misaligned PCs become a flagged NOP).
module instr_fetch_unit
  import fetch_pkg::*;
(
  input  logic        CLK,
  input  logic        Reset,
  input  logic [31:0] PC,
  output logic        PCEn,
  input  logic        Flush,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemGnt,
  input  logic        IMemRValid,
  input  logic [31:0] IMemRData,
  output logic [31:0] Instr,
  output logic [31:0] InstrPC,
  output logic        InstrValid,
`ifdef FETCH_MISALIGN_CHECK_EN
  output logic        InstrMisalign,
`endif
  input  logic        DecodeReady
);

  fetch_state_e state_q, state_d;
  logic [31:0]  addr_q;
  logic         load_addr;
  logic         fifo_push;
  logic         fifo_pop;
  logic [1:0]   fifo_count;
  logic         fifo_not_empty;
  fifo_entry_t  push_entry;
  fifo_entry_t  head_entry;

  // State register and the request address captured on entry to REQ
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load_addr) begin
        addr_q <= PC;
      end
    end
  end

  // Next state, memory handshake, PC advance and buffer push decisions
  always_comb begin
    state_d          = state_q;
    PCEn             = 1'b0;
    IMemReq          = 1'b0;
    load_addr        = 1'b0;
    fifo_push        = 1'b0;
    push_entry       = '0;
    push_entry.instr = IMemRData;
    push_entry.pc    = addr_q;
    case (state_q)
      IDLE: begin
        if (!Flush && (fifo_count < FIFO_FULL)) begin
`ifdef FETCH_MISALIGN_CHECK_EN
          if (PC[1:0] != 2'b00) begin
            fifo_push           = 1'b1;
            PCEn                = 1'b1;
            push_entry.instr    = NOP_INSTR;
            push_entry.pc       = PC;
            push_entry.misalign = 1'b1;
          end else begin
            state_d   = REQ;
            load_addr = 1'b1;
          end
`else
          state_d   = REQ;
          load_addr = 1'b1;
`endif
        end
      end
      REQ: begin
        IMemReq = 1'b1;
        if (IMemGnt) begin
          PCEn    = 1'b1;
          state_d = Flush ? DROP : WAIT;
        end else if (Flush) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (IMemRValid) begin
          fifo_push = !Flush;
          state_d   = IDLE;
        end else if (Flush) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (IMemRValid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign fifo_pop = fifo_not_empty && DecodeReady && !Flush;

  fetch_fifo u_fifo (
    .clk       (CLK),
    .rst_n     (Reset),
    .clear     (Flush),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .head      (head_entry),
    .not_empty (fifo_not_empty),
    .count     (fifo_count)
  );

  assign IMemAddr   = addr_q;
  assign Instr      = head_entry.instr;
  assign InstrPC    = head_entry.pc;
  assign InstrValid = fifo_not_empty;
`ifdef FETCH_MISALIGN_CHECK_EN
  assign InstrMisalign = head_entry.misalign;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a small memory responder and PC stage model.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN enables the misalign scenario.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] PC = 32'h0;
  logic        PCEn;
  logic        Flush = 1'b0;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemGnt = 1'b1;
  logic        IMemRValid = 1'b0;
  logic [31:0] IMemRData = 32'h0;
  logic [31:0] Instr;
  logic [31:0] InstrPC;
  logic        InstrValid;
  logic        DecodeReady = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        InstrMisalign;
`endif

  int          checks = 0;
  int          fails = 0;
  int          mem_lat = 2;
  int          rcnt = 0;
  logic [31:0] raddr = 32'h0;
  logic        force_deadbeef = 1'b0;
  logic        pc_adv = 1'b0;
  logic        flush_seen = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  int          pcen_count = 0;
  int          gnt_count = 0;
  int          req_cycles = 0;

  instr_fetch_unit dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .PC          (PC),
    .PCEn        (PCEn),
    .Flush       (Flush),
    .IMemReq     (IMemReq),
    .IMemAddr    (IMemAddr),
    .IMemGnt     (IMemGnt),
    .IMemRValid  (IMemRValid),
    .IMemRData   (IMemRData),
    .Instr       (Instr),
    .InstrPC     (InstrPC),
    .InstrValid  (InstrValid),
`ifdef FETCH_MISALIGN_CHECK_EN
    .InstrMisalign(InstrMisalign),
`endif
    .DecodeReady (DecodeReady)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hC0DE0000 | a;
  endfunction

  // Memory responder, PC-stage sampling and buffer overflow monitor, all mid-cycle
  always @(negedge CLK) begin
    IMemRValid = 1'b0;
    pc_adv     = 1'b0;
    flush_seen = 1'b0;
    if (!Reset) begin
      rcnt = 0;
    end else begin
      if (rcnt != 0) begin
        rcnt--;
        if (rcnt == 0) begin
          IMemRValid = 1'b1;
          IMemRData  = force_deadbeef ? 32'hDEADBEEF : mem_word(raddr);
        end
      end
      if (IMemReq && IMemGnt) begin
        rcnt  = mem_lat;
        raddr = IMemAddr;
        gnt_count++;
      end
      if (PCEn) begin
        pc_adv = 1'b1;
        pcen_count++;
      end
      if (IMemReq) req_cycles++;
      flush_seen = Flush;
      checks++;
      if (dut.fifo_push && dut.fifo_count == 2'd2) begin
        fails++;
        $display("[TB] FAIL fifo_overflow: push with count=%0d, required count below 2", dut.fifo_count);
      end
    end
  end

  // PC stage: redirect wins over sequential advance
  always @(posedge CLK) begin
    #1;
    if (Reset) begin
      if (flush_seen) PC = redirect_pc;
      else if (pc_adv) PC = PC + 32'd4;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  task automatic wait_valid(input int max_cycles);
    int n;
    n = 0;
    while (InstrValid !== 1'b1 && n < max_cycles) begin
      tick(1);
      n++;
    end
  endtask

  // Leaves the bench in cycle 0 after reset release (FSM in IDLE)
  task automatic do_reset(input logic [31:0] start_pc, input int lat);
    @(posedge CLK);
    #2;
    Reset = 1'b0;
    Flush = 1'b0;
    DecodeReady = 1'b0;
    IMemGnt = 1'b1;
    force_deadbeef = 1'b0;
    mem_lat = lat;
    PC = start_pc;
    tick(2);
    Reset = 1'b1;
  endtask

  task automatic test_reset();
    #3 Reset = 1'b0;
    #1;
    checks++; if (IMemReq !== 1'b0) begin fails++; $display("[TB] FAIL reset_imemreq: got %b, required 0", IMemReq); end
    checks++; if (PCEn !== 1'b0) begin fails++; $display("[TB] FAIL reset_pcen: got %b, required 0", PCEn); end
    checks++; if (InstrValid !== 1'b0) begin fails++; $display("[TB] FAIL reset_instrvalid: got %b, required 0", InstrValid); end
    checks++; if (IMemAddr !== 32'h0) begin fails++; $display("[TB] FAIL reset_imemaddr: got %h, required 0", IMemAddr); end
    checks++; if (Instr !== 32'h0) begin fails++; $display("[TB] FAIL reset_instr: got %h, required 0", Instr); end
    checks++; if (InstrPC !== 32'h0) begin fails++; $display("[TB] FAIL reset_instrpc: got %h, required 0", InstrPC); end
  endtask

  task automatic test_single_fetch();
    do_reset(32'h0, 2);
    pcen_count = 0;
    checks++; if (IMemReq !== 1'b0) begin fails++; $display("[TB] FAIL single_c0_req: got %b, required 0", IMemReq); end
    tick(1);
    checks++; if (IMemReq !== 1'b1) begin fails++; $display("[TB] FAIL single_c1_req: got %b, required 1", IMemReq); end
    checks++; if (IMemAddr !== 32'h0) begin fails++; $display("[TB] FAIL single_c1_addr: got %h, required 0", IMemAddr); end
    checks++; if (PCEn !== 1'b1) begin fails++; $display("[TB] FAIL single_c1_pcen: got %b, required 1", PCEn); end
    tick(1);
    checks++; if (PCEn !== 1'b0) begin fails++; $display("[TB] FAIL single_c2_pcen: got %b, required 0", PCEn); end
    checks++; if (IMemReq !== 1'b0) begin fails++; $display("[TB] FAIL single_c2_req: got %b, required 0", IMemReq); end
    tick(1);
    checks++; if (InstrValid !== 1'b0) begin fails++; $display("[TB] FAIL single_c3_valid: got %b, required 0", InstrValid); end
    tick(1);
    checks++; if (InstrValid !== 1'b1) begin fails++; $display("[TB] FAIL single_c4_valid: got %b, required 1", InstrValid); end
    checks++; if (Instr !== 32'hC0DE0000) begin fails++; $display("[TB] FAIL single_instr: got %h, required c0de0000", Instr); end
    checks++; if (InstrPC !== 32'h0) begin fails++; $display("[TB] FAIL single_instrpc: got %h, required 0", InstrPC); end
    checks++; if (pcen_count != 1) begin fails++; $display("[TB] FAIL single_pcen_pulses: got %0d, required 1", pcen_count); end
  endtask

  task automatic test_back_pressure();
    do_reset(32'h0, 1);
    gnt_count = 0;
    tick(10);
    req_cycles = 0;
    tick(6);
    checks++; if (gnt_count != 2) begin fails++; $display("[TB] FAIL bp_grants: got %0d, required 2", gnt_count); end
    checks++; if (req_cycles != 0) begin fails++; $display("[TB] FAIL bp_no_third_req: got %0d request cycles, required 0", req_cycles); end
    checks++; if (PC !== 32'h8) begin fails++; $display("[TB] FAIL bp_pc: got %h, required 8", PC); end
    checks++; if (InstrValid !== 1'b1) begin fails++; $display("[TB] FAIL bp_valid: got %b, required 1", InstrValid); end
    checks++; if (InstrPC !== 32'h0) begin fails++; $display("[TB] FAIL bp_head0_pc: got %h, required 0", InstrPC); end
    checks++; if (Instr !== 32'hC0DE0000) begin fails++; $display("[TB] FAIL bp_head0_instr: got %h, required c0de0000", Instr); end
    DecodeReady = 1'b1;
    tick(1);
    checks++; if (InstrPC !== 32'h4) begin fails++; $display("[TB] FAIL bp_head1_pc: got %h, required 4", InstrPC); end
    checks++; if (Instr !== 32'hC0DE0004) begin fails++; $display("[TB] FAIL bp_head1_instr: got %h, required c0de0004", Instr); end
    tick(1);
    DecodeReady = 1'b0;
    checks++; if (InstrValid !== 1'b0) begin fails++; $display("[TB] FAIL bp_drained: got %b, required 0", InstrValid); end
    checks++; if (IMemReq !== 1'b1) begin fails++; $display("[TB] FAIL bp_refetch_req: got %b, required 1", IMemReq); end
    checks++; if (IMemAddr !== 32'h8) begin fails++; $display("[TB] FAIL bp_refetch_addr: got %h, required 8", IMemAddr); end
  endtask

  task automatic test_push_pop();
    do_reset(32'h0, 1);
    tick(3);
    checks++; if (InstrValid !== 1'b1) begin fails++; $display("[TB] FAIL pp_first_valid: got %b, required 1", InstrValid); end
    checks++; if (InstrPC !== 32'h0) begin fails++; $display("[TB] FAIL pp_first_pc: got %h, required 0", InstrPC); end
    tick(2);
    DecodeReady = 1'b1;
    tick(1);
    checks++; if (InstrValid !== 1'b1) begin fails++; $display("[TB] FAIL pp_valid: got %b, required 1", InstrValid); end
    checks++; if (InstrPC !== 32'h4) begin fails++; $display("[TB] FAIL pp_head_pc: got %h, required 4", InstrPC); end
    checks++; if (Instr !== 32'hC0DE0004) begin fails++; $display("[TB] FAIL pp_head_instr: got %h, required c0de0004", Instr); end
    tick(1);
    DecodeReady = 1'b0;
    checks++; if (InstrValid !== 1'b0) begin fails++; $display("[TB] FAIL pp_count_one: got valid %b, required 0", InstrValid); end
    checks++; if (IMemReq !== 1'b1) begin fails++; $display("[TB] FAIL pp_next_req: got %b, required 1", IMemReq); end
  endtask

  task automatic test_flush_wait();
    do_reset(32'h8, 1);
    force_deadbeef = 1'b1;
    tick(2);
    checks++; if (IMemReq !== 1'b0) begin fails++; $display("[TB] FAIL fw_wait_req: got %b, required 0", IMemReq); end
    Flush = 1'b1;
    redirect_pc = 32'h100;
    tick(1);
    Flush = 1'b0;
    force_deadbeef = 1'b0;
    checks++; if (InstrValid !== 1'b0) begin fails++; $display("[TB] FAIL fw_discard_valid: got %b, required 0", InstrValid); end
    checks++; if (Instr !== 32'h0) begin fails++; $display("[TB] FAIL fw_discard_instr: got %h, required 0", Instr); end
    tick(1);
    checks++; if (IMemReq !== 1'b1) begin fails++; $display("[TB] FAIL fw_new_req: got %b, required 1", IMemReq); end
    checks++; if (IMemAddr !== 32'h100) begin fails++; $display("[TB] FAIL fw_new_addr: got %h, required 100", IMemAddr); end
    wait_valid(10);
    checks++; if (InstrValid !== 1'b1) begin fails++; $display("[TB] FAIL fw_timeout: valid %b after 10 cycles, required 1", InstrValid); end
    checks++; if (InstrPC !== 32'h100) begin fails++; $display("[TB] FAIL fw_instrpc: got %h, required 100", InstrPC); end
    checks++; if (Instr !== 32'hC0DE0100) begin fails++; $display("[TB] FAIL fw_instr: got %h, required c0de0100", Instr); end
  endtask

  task automatic test_flush_grant();
    do_reset(32'h0, 2);
    DecodeReady = 1'b1;
    tick(1);
    pcen_count = 0;
    Flush = 1'b1;
    redirect_pc = 32'h200;
    #1;
    checks++; if (PCEn !== 1'b1) begin fails++; $display("[TB] FAIL fg_pcen: got %b, required 1", PCEn); end
    tick(1);
    Flush = 1'b0;
    checks++; if (IMemReq !== 1'b0) begin fails++; $display("[TB] FAIL fg_drop_req: got %b, required 0", IMemReq); end
    tick(2);
    checks++; if (InstrValid !== 1'b0) begin fails++; $display("[TB] FAIL fg_dropped: got valid %b, required 0", InstrValid); end
    checks++; if (pcen_count != 1) begin fails++; $display("[TB] FAIL fg_pcen_once: got %0d pulses, required 1", pcen_count); end
    checks++; if (IMemReq !== 1'b0) begin fails++; $display("[TB] FAIL fg_idle_req: got %b, required 0", IMemReq); end
    tick(1);
    checks++; if (IMemAddr !== 32'h200) begin fails++; $display("[TB] FAIL fg_new_addr: got %h, required 200", IMemAddr); end
    wait_valid(10);
    DecodeReady = 1'b0;
    checks++; if (InstrPC !== 32'h200) begin fails++; $display("[TB] FAIL fg_instrpc: got %h, required 200", InstrPC); end
    checks++; if (Instr !== 32'hC0DE0200) begin fails++; $display("[TB] FAIL fg_instr: got %h, required c0de0200", Instr); end
  endtask

  task automatic test_reset_mid_request();
    do_reset(32'h0, 3);
    tick(1);
    checks++; if (IMemReq !== 1'b1) begin fails++; $display("[TB] FAIL rm_req_before: got %b, required 1", IMemReq); end
    #1 Reset = 1'b0;
    #1;
    checks++; if (IMemReq !== 1'b0) begin fails++; $display("[TB] FAIL rm_req_async: got %b, required 0", IMemReq); end
    checks++; if (PCEn !== 1'b0) begin fails++; $display("[TB] FAIL rm_pcen_async: got %b, required 0", PCEn); end
    tick(2);
    Reset = 1'b1;
    tick(1);
    checks++; if (IMemAddr !== 32'h0) begin fails++; $display("[TB] FAIL rm_restart_addr: got %h, required 0", IMemAddr); end
    wait_valid(12);
    checks++; if (InstrPC !== 32'h0) begin fails++; $display("[TB] FAIL rm_instrpc: got %h, required 0", InstrPC); end
    checks++; if (Instr !== 32'hC0DE0000) begin fails++; $display("[TB] FAIL rm_instr: got %h, required c0de0000", Instr); end
  endtask

`ifdef FETCH_MISALIGN_CHECK_EN
  task automatic test_misalign();
    do_reset(32'h6, 1);
    req_cycles = 0;
    #1;
    checks++; if (PCEn !== 1'b1) begin fails++; $display("[TB] FAIL ma_pcen: got %b, required 1", PCEn); end
    tick(1);
    checks++; if (InstrValid !== 1'b1) begin fails++; $display("[TB] FAIL ma_valid: got %b, required 1", InstrValid); end
    checks++; if (Instr !== 32'h00000013) begin fails++; $display("[TB] FAIL ma_instr: got %h, required 00000013", Instr); end
    checks++; if (InstrPC !== 32'h6) begin fails++; $display("[TB] FAIL ma_instrpc: got %h, required 6", InstrPC); end
    checks++; if (InstrMisalign !== 1'b1) begin fails++; $display("[TB] FAIL ma_flag: got %b, required 1", InstrMisalign); end
    tick(4);
    checks++; if (req_cycles != 0) begin fails++; $display("[TB] FAIL ma_no_req: got %0d request cycles, required 0", req_cycles); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_fetch();
    test_back_pressure();
    test_push_pop();
    test_flush_wait();
    test_flush_grant();
    test_reset_mid_request();
`ifdef FETCH_MISALIGN_CHECK_EN
    test_misalign();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port Reset, input, 1, asynchronous active-low reset (asserted at 0).
REQ-003 SHALL have port PC, input, 32, fetch address from the program counter stage.
REQ-004 SHALL have port PCEn, output, 1, a one-cycle pulse to the program counter stage to advance PC.
REQ-005 SHALL have port Flush, input, 1, redirect (branch, jump or JALR) taken this cycle.
REQ-006 SHALL have port IMemReq, output, 1, instruction memory request valid.
REQ-007 SHALL have port IMemAddr, output, 32, instruction memory request address.
REQ-008 SHALL have port IMemGnt, input, 1, memory accepts the request this cycle.
REQ-009 SHALL have port IMemRValid, input, 1, read data valid.
REQ-010 SHALL have port IMemRData, input, 32, read data.
REQ-011 SHALL have port Instr, output, 32, instruction presented to decode.
REQ-012 SHALL have port InstrPC, output, 32, address of Instr.
REQ-013 SHALL have port InstrValid, output, 1, Instr/InstrPC valid.
REQ-014 SHALL have port DecodeReady, input, 1, decode consumes Instr this cycle.

Function
REQ-015 SHALL implement FSM states IDLE, REQ, WAIT and DROP, with at most one memory request outstanding.
REQ-016 SHALL hold a 2-entry FIFO of {instruction, PC}; InstrValid = FIFO non-empty; Instr/InstrPC = FIFO head.
REQ-017 IDLE -> REQ SHALL occur when Flush=0 and (FIFO count + outstanding) < 2.
REQ-018 In REQ, IMemReq=1 and IMemAddr=PC (registered at REQ entry, held stable until grant).
REQ-019 REQ -> WAIT on IMemGnt=1, with PCEn=1 in that same cycle only.
REQ-020 In WAIT, IMemRValid=1 SHALL push {IMemRData, latched address} into the FIFO and go to IDLE.
REQ-021 Pop SHALL occur when InstrValid=1 and DecodeReady=1; simultaneous push and pop SHALL leave the count unchanged.
REQ-022 Push into a full FIFO is impossible by REQ-017, and the bench SHALL assert that it never occurs.
REQ-023 Flush SHALL clear the FIFO in the same cycle, so that InstrValid=0 from the next cycle; a pop in the same cycle is ignored.
REQ-024 Flush in IDLE, or in REQ without grant, SHALL go to IDLE with IMemReq dropped next cycle and no PCEn.
REQ-025 Flush in REQ with grant, or in WAIT without IMemRValid, SHALL go to DROP.
REQ-026 Flush in WAIT with IMemRValid SHALL discard that data and go to IDLE.
REQ-027 DROP SHALL discard the next IMemRValid response and then go to IDLE; no push occurs.
REQ-028 Minimum latency SHALL be 1 cycle from grant to push, and 1 further cycle until InstrValid.

Reset
REQ-029 Reset=0 SHALL immediately set the state to IDLE, clear the FIFO, and drive IMemReq, PCEn, InstrValid=0 and IMemAddr, Instr, InstrPC=0.
REQ-030 Reset asserted mid-request SHALL abandon the request; the memory system is reset concurrently.

Configuration
REQ-031 Macro FETCH_MISALIGN_CHECK_EN defined: a request with PC[1:0]!=0 SHALL not be issued; the block SHALL push {NOP 32'h00000013, PC} with an extra output InstrMisalign=1 carried per FIFO entry, and pulse PCEn.
REQ-032 Macro undefined: there SHALL be no InstrMisalign port and no check; PC[1:0] SHALL be passed to IMemAddr unchanged.

Structure
REQ-033 Package fetch_pkg SHALL contain the FSM state enum typedef, the FIFO entry struct typedef, localparam FIFO_DEPTH=2 and localparam NOP_INSTR=32'h00000013.
REQ-034 The FIFO SHALL be a separate sub-module named fetch_fifo, instantiated once.

Verification
REQ-035 Reset: Reset=0 then 1, PC=0, IMemGnt=1, 2-cycle memory latency -> IMemReq at cycle 1, PCEn pulse, Instr=mem[0] with InstrPC=0 and InstrValid=1.
REQ-036 Back-pressure: DecodeReady=0, sequential PCs 0,4,8 -> exactly 2 entries buffered, no third IMemReq; DecodeReady=1 -> entries for PC 0 and 4 popped in order, then fetch of 8 issued.
REQ-037 Flush during WAIT at PC=8: response 32'hDEADBEEF -> discarded, InstrValid=0; next fetch from new PC=32'h100 delivers InstrPC=32'h100.
REQ-038 Flush with grant in the same cycle -> DROP, one response dropped, PCEn pulsed exactly once.
REQ-039 Push and pop in the same cycle with count=1 -> count stays 1, head advances correctly.
REQ-040 With FETCH_MISALIGN_CHECK_EN and PC=32'h6 -> no IMemReq, Instr=32'h00000013, InstrMisalign=1, InstrPC=32'h6.
